// File: rtl/hash_writer_if.sv
// Digest handshake and output-memory write bus for hash_writer.
// The master side is the controller/core feeding the digest; the slave side
// is hash_writer itself.
interface hash_writer_if #(
  parameter int NUM_WORDS  = 8,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                            start;
  logic                            hash_valid;
  logic [NUM_WORDS*WORD_WIDTH-1:0] hash_in;
  logic                            hash_ready;
  logic                            write_enable;
  logic [ADDR_WIDTH-1:0]           write_address;
  logic [WORD_WIDTH-1:0]           write_data;
  logic                            write_complete;

  modport master (
    output start, hash_valid, hash_in,
    input  hash_ready, write_enable, write_address, write_data, write_complete
  );

  modport slave (
    input  start, hash_valid, hash_in,
    output hash_ready, write_enable, write_address, write_data, write_complete
  );
endinterface

// File: rtl/hash_writer.sv
// Captures a SHA-256 digest over valid/ready, then streams it one word per
// clock into the output memory starting at BASE_ADDR and flags completion.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a digest; hash_ready follows start
// S_WRITE | one word written per cycle, index selects the word
// S_DONE  | all words written, write_complete held until start drops
module hash_writer #(
  parameter int NUM_WORDS  = 8,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = 0
) (
  input  logic          clock,
  input  logic          reset,
  hash_writer_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  state_t                r_state;
  logic [IW-1:0]         r_index;
  logic [WORD_WIDTH-1:0] r_buf [NUM_WORDS];
  logic                  r_we;
  logic                  r_complete;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0] r_data;

  logic                  w_ready;
  logic                  w_transfer;
  logic [IW-1:0]         w_next_index;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [WORD_WIDTH-1:0] w_hash_word0;

  // reset gates ready so it drops immediately on async reset, not at an edge
  assign w_ready      = !reset && (r_state == S_IDLE) && bus.start;
  assign w_transfer   = w_ready && bus.hash_valid;
  assign w_next_index = r_index + 1'b1;
  assign w_next_addr  = BASE + ADDR_WIDTH'(w_next_index);
  assign w_hash_word0 = bus.hash_in[NUM_WORDS*WORD_WIDTH-1 -: WORD_WIDTH];

  // Sequencer: state, index, digest buffer and registered write outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_index    <= '0;
      r_we       <= 1'b0;
      r_complete <= 1'b0;
      r_addr     <= BASE;
      r_data     <= '0;
      for (int i = 0; i < NUM_WORDS; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_transfer) begin
            // H0 sits in the MSBs, so word i is counted down from the top
            for (int i = 0; i < NUM_WORDS; i++)
              r_buf[i] <= bus.hash_in[(NUM_WORDS-1-i)*WORD_WIDTH +: WORD_WIDTH];
            r_index    <= '0;
            r_state    <= S_WRITE;
            r_we       <= 1'b1;
            r_addr     <= BASE;
            r_data     <= w_hash_word0;
            r_complete <= 1'b0;
          end
        end
        S_WRITE: begin
          if (!bus.start) begin
            // abort: drop the partial transfer without signalling completion
            r_state <= S_IDLE;
            r_index <= '0;
            r_we    <= 1'b0;
          end else if (r_index == LAST_IDX) begin
            // address and data keep showing the last word while in DONE
            r_state    <= S_DONE;
            r_we       <= 1'b0;
            r_complete <= 1'b1;
          end else begin
            r_index <= w_next_index;
            r_we    <= 1'b1;
            r_addr  <= w_next_addr;
            r_data  <= r_buf[w_next_index];
          end
        end
        S_DONE: begin
          if (!bus.start) begin
            r_state    <= S_IDLE;
            r_index    <= '0;
            r_complete <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_index <= '0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hash_ready     = w_ready;
  assign bus.write_enable   = r_we;
  assign bus.write_address  = r_addr;
  assign bus.write_data     = r_data;
  assign bus.write_complete = r_complete;
endmodule

// File: tb/tb_hash_writer.sv
// Bench for hash_writer: three instances (default, wrapping base address,
// four-word digest). Expected writes go into per-instance queues when a digest
// is offered; a monitor pops and compares every write strobe it sees.
module tb_hash_writer;
  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;

  logic [47:0] q [3][$];

  hash_writer_if b0 ();
  hash_writer_if b1 ();
  hash_writer_if #(.NUM_WORDS(4)) b2 ();

  hash_writer u0 (.clock(clk), .reset(rst), .bus(b0));
  hash_writer #(.BASE_ADDR(16'hFFFC)) u1 (.clock(clk), .reset(rst), .bus(b1));
  hash_writer #(.NUM_WORDS(4)) u2 (.clock(clk), .reset(rst), .bus(b2));

  localparam logic [255:0] ABC  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] SEQ  = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
  localparam logic [255:0] JUNK = 256'hdeadbeef_cafef00d_0badf00d_feedface_12345678_9abcdef0_55aa55aa_a5a5a5a5;
  localparam logic [255:0] D3   = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
  localparam logic [255:0] D4   = 256'ha0a0a0a0_b1b1b1b1_c2c2c2c2_d3d3d3d3_e4e4e4e4_f5f5f5f5_06060606_17171717;
  localparam logic [255:0] SQB  = 256'h000000aa_000000bb_000000cc_000000dd_000000ee_000000ff_00000100_00000200;
  localparam logic [127:0] Q4   = 128'hc0de0001_c0de0002_c0de0003_c0de0004;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Queue the first cnt writes expected for an n-word digest h (right-aligned)
  task automatic push(input int k, input logic [15:0] base, input int n,
                      input logic [255:0] h, input int cnt);
    logic [15:0] a;
    logic [31:0] d;
    for (int i = 0; i < cnt; i++) begin
      a = base + 16'(i);
      d = h[(n-1-i)*32 +: 32];
      q[k].push_back({a, d});
    end
  endtask

  task automatic mon(input int k, input logic we, input logic [15:0] a, input logic [31:0] d);
    logic [47:0] exp;
    if (we) begin
      checks++;
      if (q[k].size() == 0) begin
        errors++;
        $display("FAIL unexpected_write dut%0d: got addr=%h data=%h, required no write", k, a, d);
      end else begin
        exp = q[k].pop_front();
        if ({a, d} !== exp) begin
          errors++;
          $display("FAIL write dut%0d: got addr=%h data=%h, required addr=%h data=%h",
                   k, a, d, exp[47:32], exp[31:0]);
        end
      end
    end
  endtask

  // Monitor: compare every write strobe against the scoreboard queues
  initial begin
    forever begin
      @(negedge clk);
      mon(0, b0.write_enable, b0.write_address, b0.write_data);
      mon(1, b1.write_enable, b1.write_address, b1.write_data);
      mon(2, b2.write_enable, b2.write_address, b2.write_data);
    end
  end

  initial begin
    rst = 1'b1;
    b0.start = 1'b0; b0.hash_valid = 1'b0; b0.hash_in = '0;
    b1.start = 1'b0; b1.hash_valid = 1'b0; b1.hash_in = '0;
    b2.start = 1'b0; b2.hash_valid = 1'b0; b2.hash_in = '0;
    b0.start = 1'b1;
    tick(); tick();
    chk("rst_ready", 48'(b0.hash_ready), 48'd0);
    chk("rst_we", 48'(b0.write_enable), 48'd0);
    chk("rst_addr", 48'(b0.write_address), 48'd0);
    chk("rst_data", 48'(b0.write_data), 48'd0);
    chk("rst_complete", 48'(b0.write_complete), 48'd0);
    rst = 1'b0;

    // basic write of the "abc" digest; hash_valid stays high with other data
    tick();
    chk("idle_ready", 48'(b0.hash_ready), 48'd1);
    b0.hash_valid = 1'b1; b0.hash_in = ABC;
    push(0, 16'h0000, 8, ABC, 8);
    tick();
    b0.hash_in = JUNK;
    repeat (7) tick();
    tick();
    chk("done_complete", 48'(b0.write_complete), 48'd1);
    chk("done_we", 48'(b0.write_enable), 48'd0);
    chk("done_ready", 48'(b0.hash_ready), 48'd0);
    chk("done_addr", 48'(b0.write_address), 48'd7);
    chk("done_data", 48'(b0.write_data), 48'hf20015ad);
    repeat (3) begin
      tick();
      chk("complete_hold", 48'(b0.write_complete), 48'd1);
    end
    b0.start = 1'b0;
    tick();
    chk("complete_clear", 48'(b0.write_complete), 48'd0);
    chk("ready_start_low", 48'(b0.hash_ready), 48'd0);

    // second digest after start 1->0->1
    b0.hash_in = SEQ; b0.start = 1'b1;
    push(0, 16'h0000, 8, SEQ, 8);
    repeat (8) tick();
    tick();
    chk("second_complete", 48'(b0.write_complete), 48'd1);
    chk("second_data", 48'(b0.write_data), 48'd8);
    b0.start = 1'b0; b0.hash_valid = 1'b0;
    tick();

    // abort after the write to address 2
    b0.start = 1'b1; b0.hash_valid = 1'b1; b0.hash_in = D3;
    push(0, 16'h0000, 8, D3, 3);
    repeat (3) tick();
    b0.start = 1'b0; b0.hash_valid = 1'b0;
    tick();
    chk("abort_we", 48'(b0.write_enable), 48'd0);
    repeat (5) begin
      tick();
      chk("abort_complete", 48'(b0.write_complete), 48'd0);
    end
    b0.start = 1'b1;
    #1;
    chk("abort_ready", 48'(b0.hash_ready), 48'd1);

    // async reset during the write to address 5
    tick();
    b0.hash_valid = 1'b1; b0.hash_in = D4;
    push(0, 16'h0000, 8, D4, 6);
    repeat (6) tick();
    b0.hash_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_we", 48'(b0.write_enable), 48'd0);
    chk("arst_complete", 48'(b0.write_complete), 48'd0);
    chk("arst_ready", 48'(b0.hash_ready), 48'd0);
    chk("arst_addr", 48'(b0.write_address), 48'd0);
    chk("arst_data", 48'(b0.write_data), 48'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 48'(b0.hash_ready), 48'd1);

    // start low with hash_valid high: nothing accepted, nothing written
    b0.start = 1'b0; b0.hash_valid = 1'b1;
    repeat (20) begin
      tick();
      chk("startlow_ready", 48'(b0.hash_ready), 48'd0);
    end
    b0.hash_valid = 1'b0; b0.start = 1'b1;
    #1;
    chk("startlow_idle", 48'(b0.hash_ready), 48'd1);
    b0.start = 1'b0;

    // base address near the top wraps through zero
    tick();
    b1.start = 1'b1; b1.hash_valid = 1'b1; b1.hash_in = SQB;
    push(1, 16'hFFFC, 8, SQB, 8);
    tick();
    b1.hash_valid = 1'b0;
    repeat (7) tick();
    tick();
    chk("wrap_complete", 48'(b1.write_complete), 48'd1);
    chk("wrap_last_addr", 48'(b1.write_address), 48'h0003);
    b1.start = 1'b0;

    // four-word digest
    tick();
    b2.start = 1'b1; b2.hash_valid = 1'b1; b2.hash_in = Q4;
    push(2, 16'h0000, 4, {128'd0, Q4}, 4);
    tick();
    b2.hash_valid = 1'b0;
    repeat (3) tick();
    tick();
    chk("n4_complete", 48'(b2.write_complete), 48'd1);
    chk("n4_last_addr", 48'(b2.write_address), 48'd3);
    b2.start = 1'b0;
    repeat (3) tick();

    chk("q0_drained", 48'(q[0].size()), 48'd0);
    chk("q1_drained", 48'(q[1].size()), 48'd0);
    chk("q2_drained", 48'(q[2].size()), 48'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hash_writer.md
Name: hash_writer

Overview:
- Write-side counterpart to the W/K read-address counter.
- Accepts the final SHA-256 digest from the compression core through a valid/ready handshake and buffers all words internally.
- Streams the words one per clock into the output memory, with write enable, address and data.
- Flags completion, which the top-level controller samples.

Parameters:
NUM_WORDS, 8, number of digest words written per transfer (H0..H7).
WORD_WIDTH, 32, bits per digest word.
ADDR_WIDTH, 16, width of the output memory address.
BASE_ADDR, 0, address at which H0 is written; word i goes to BASE_ADDR+i.

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high; clears all state.
start  input  1  level enable; low forces the block back to IDLE.
hash_valid  input  1  digest on hash_in is valid.
hash_in  input  NUM_WORDS*WORD_WIDTH  packed digest; H0 occupies the MSBs.
hash_ready  output  1  block can accept a digest.
write_enable  output  1  memory write strobe.
write_address  output  ADDR_WIDTH  memory write address.
write_data  output  WORD_WIDTH  memory write data.
write_complete  output  1  all NUM_WORDS words written.

Behaviour:
- States: IDLE, WRITE, DONE. The word index is $clog2(NUM_WORDS) bits wide.
- All outputs are decoded from registered state (state, index, buffer); there is no input-to-output combinational path except via start gating hash_ready.
- Reset (async assert, released synchronously by the system):
  - state=IDLE, index=0, buffer=0.
  - Outputs: hash_ready=0 while reset is asserted, write_enable=0, write_address=BASE_ADDR, write_data=0, write_complete=0.
- hash_ready = (state==IDLE) && start.
- IDLE:
  - Transfer occurs at an edge where hash_valid && hash_ready.
  - At that edge: capture hash_in into the buffer, index<=0, state<=WRITE.
  - hash_valid while start=0 is ignored; no capture.
- WRITE:
  - write_enable=1, write_address=BASE_ADDR+index, write_data=buffer word[index] (word 0 = H0 = hash_in MSBs).
  - Each edge with start=1: if index==NUM_WORDS-1, state<=DONE; else index<=index+1.
  - First write is visible the cycle after the transfer edge. NUM_WORDS consecutive write cycles, no bubbles.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH.
- DONE:
  - write_complete=1, write_enable=0, hash_ready=0.
  - write_address holds BASE_ADDR+NUM_WORDS-1 and write_data holds the last word.
  - Stays in DONE while start=1; start=0 -> IDLE, index<=0, write_complete cleared the next cycle.
- start deasserted mid-WRITE: abort. Next edge state<=IDLE and index<=0; write_enable low from that cycle; no write_complete pulse.
- Reset mid-WRITE: immediate (async) return to reset values; the partial digest is discarded.
- The buffer is not modified outside the transfer edge. A new digest is accepted only after returning to IDLE.

Test Plan:
- Basic write:
  - Stimulus: start=1; hash_valid=1 with hash_in = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad (the "abc" digest).
  - Required: hash_ready=1 in IDLE; 8 consecutive cycles with write_enable=1, addresses 0..7 carrying those words in order; write_complete=1 from the next cycle and held while start=1.
- Back-to-back:
  - Stimulus: hash_valid held high during WRITE/DONE.
  - Required: no second capture. After start 1->0->1 a second digest (all words 0x00000001..0x00000008) is written to 0..7.
- Abort:
  - Stimulus: drop start after the 3rd write cycle (address 2).
  - Required: write_enable=0 the next cycle; write_complete never asserts; hash_ready returns to 1 when start reasserts.
- Async reset:
  - Stimulus: assert reset mid-cycle during address 5.
  - Required: write_enable, write_complete and hash_ready fall without waiting for a clock edge; write_address=BASE_ADDR.
- Parameter sweep:
  - Stimulus: BASE_ADDR=0xFFFC, ADDR_WIDTH=16.
  - Required: addresses FFFC, FFFD, FFFE, FFFF, 0000..0003 (wrap).
  - Stimulus: NUM_WORDS=4.
  - Required: exactly 4 writes.
- Start low:
  - Stimulus: start=0 with hash_valid=1 for 20 cycles.
  - Required: hash_ready=0, no writes, state remains IDLE.
